// File: rtl/dp_ram_loader_pkg.sv
// Shared constants and FSM encoding for the burst-loaded dual-port RAM.
package dp_ram_loader_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  // Plain-constant encoding keeps the state register readable in legacy waveform tools.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/dp_ram_16x8.sv
// 16x8 storage: one synchronous write port, synchronous clear, two combinational read ports.
module dp_ram_16x8
  import dp_ram_loader_pkg::*;
#(
  parameter int ADDR_W = dp_ram_loader_pkg::ADDR_W,
  parameter int DATA_W = dp_ram_loader_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port with full-array clear on reset.
  // NOTE: clearing every word on reset rules out a RAM macro and builds this from flops; at 16 bytes that is the right trade for a known power-up table.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) begin
        // NOTE: non-blocking so reads in the write cycle still see the old word until the edge.
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/dp_ram_loader.sv
// Burst loader: fills consecutive RAM addresses (wrapping) from a valid/ready byte stream.
module dp_ram_loader
  import dp_ram_loader_pkg::*;
#(
  parameter int ADDR_W = dp_ram_loader_pkg::ADDR_W,
  parameter int DATA_W = dp_ram_loader_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b
);

  localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W + 1)'(2 ** ADDR_W);

  logic [1:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W:0]   len_sat;
  logic              hs;

  assign in_ready = (state == ST_LOAD);
  assign busy     = in_ready;
  assign done     = (state == ST_DONE);
  assign hs       = in_valid && in_ready;

  // A burst can never usefully exceed the array size, so longer requests clamp to one full pass.
  always_comb begin
    len_sat = (len > FULL_LEN) ? FULL_LEN : len;
  end

  // Loader FSM, write pointer and byte counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      remaining <= '0;
      wr_count  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            ptr       <= base_addr;
            remaining <= len_sat;
            wr_count  <= '0;
            state     <= (len_sat == '0) ? ST_DONE : ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (hs) begin
            ptr       <= ptr + 1'b1;
            remaining <= remaining - 1'b1;
            wr_count  <= wr_count + 1'b1;
            if (remaining == (ADDR_W + 1)'(1)) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  dp_ram_16x8 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (hs),
    .waddr   (ptr),
    .wdata   (in_data),
    .raddr_a (addr_a),
    .rdata_a (data_a),
    .raddr_b (addr_b),
    .rdata_b (data_b)
  );

endmodule

// File: tb/tb_dp_ram_loader.sv
// Scoreboard bench for dp_ram_loader: a byte-level memory model plus a queue of expected writes.
module tb_dp_ram_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] base_addr;
  logic [4:0] len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic [4:0] wr_count;
  logic [3:0] addr_a;
  logic [3:0] addr_b;
  logic [7:0] data_a;
  logic [7:0] data_b;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        sb[$];
  logic [7:0] model[16];
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  dp_ram_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .busy      (busy),
    .done      (done),
    .wr_count  (wr_count),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .data_a    (data_a),
    .data_b    (data_b)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start sampled at the next edge; returns one step into cycle N+1.
  task automatic start_burst(input logic [3:0] b, input logic [4:0] l);
    start = 1'b1; base_addr = b; len = l;
    tick();
    start = 1'b0;
  endtask

  // Offers one byte for exactly one edge; the model and scoreboard record the expected write.
  task automatic send_byte(input logic [7:0] d, input logic [3:0] exp_addr, input string tag);
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL %s in_ready: got %b want 1", tag, in_ready);
    end
    in_valid = 1'b1; in_data = d;
    sb.push_back('{addr: exp_addr, data: d});
    model[exp_addr] = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_flags(input string tag, input logic e_busy, input logic e_done,
                             input logic [4:0] e_cnt);
    total++;
    if (busy !== e_busy || in_ready !== e_busy || done !== e_done || wr_count !== e_cnt) begin
      bad++;
      $display("FAIL %s flags: busy=%b in_ready=%b done=%b wr_count=%0d want busy=%b done=%b wr_count=%0d",
               tag, busy, in_ready, done, wr_count, e_busy, e_done, e_cnt);
    end
  endtask

  task automatic drain(input string tag);
    while (sb.size() > 0) begin
      wr_t w;
      w = sb.pop_front();
      addr_a = w.addr; #1;
      total++;
      if (data_a !== w.data) begin
        bad++; $display("FAIL %s write@%0d: got %h want %h", tag, w.addr, data_a, w.data);
      end
    end
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 16; i++) begin
      addr_a = 4'(i); addr_b = 4'(15 - i); #1;
      total++;
      if (data_a !== model[i] || data_b !== model[15 - i]) begin
        bad++;
        $display("FAIL %s sweep@%0d: a=%h want %h b=%h want %h",
                 tag, i, data_a, model[i], data_b, model[15 - i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0;
    in_valid = 1'b0; in_data = '0; addr_a = '0; addr_b = '0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    check_flags("reset", 1'b0, 1'b0, 5'd0);
    sweep("reset");
  endtask

  task automatic test_full_burst();
    logic [7:0] pat[16];
    pat = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0,
            8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    start_burst(4'd0, 5'd16);
    for (int i = 0; i < 16; i++) begin
      check_flags("full_step", 1'b1, 1'b0, 5'(i));
      send_byte(pat[i], 4'(i), "full");
    end
    check_flags("full_done", 1'b0, 1'b1, 5'd16);
    tick();
    check_flags("full_after", 1'b0, 1'b0, 5'd16);
    drain("full");
    addr_a = 4'd5; addr_b = 4'd15; #1;
    total++;
    if (data_a !== 8'hBC || data_b !== 8'h88) begin
      bad++; $display("FAIL full_fixed: a=%h want bc b=%h want 88", data_a, data_b);
    end
  endtask

  task automatic test_wrap_stall();
    start_burst(4'd14, 5'd4);
    send_byte(8'hA1, 4'd14, "wrap");
    send_byte(8'hA2, 4'd15, "wrap");
    for (int i = 0; i < 3; i++) begin
      check_flags("wrap_stall", 1'b1, 1'b0, 5'd2);
      tick();
    end
    send_byte(8'hA3, 4'd0, "wrap");
    send_byte(8'hA4, 4'd1, "wrap");
    check_flags("wrap_done", 1'b0, 1'b1, 5'd4);
    tick();
    drain("wrap");
    sweep("wrap");
  endtask

  task automatic test_zero_len();
    start_burst(4'd6, 5'd0);
    check_flags("zero_done", 1'b0, 1'b1, 5'd0);
    tick();
    check_flags("zero_idle", 1'b0, 1'b0, 5'd0);
    sweep("zero");
  endtask

  task automatic test_ignored_start();
    start_burst(4'd8, 5'd2);
    send_byte(8'hC8, 4'd8, "ign");
    start = 1'b1; base_addr = 4'd2; len = 5'd5;
    send_byte(8'hC9, 4'd9, "ign");
    start = 1'b0;
    check_flags("ign_done", 1'b0, 1'b1, 5'd2);
    tick();
    check_flags("ign_idle", 1'b0, 1'b0, 5'd2);
    drain("ign");
    sweep("ign");
  endtask

  task automatic test_saturate();
    start_burst(4'd4, 5'd20);
    for (int i = 0; i < 16; i++) begin
      check_flags("sat_step", 1'b1, 1'b0, 5'(i));
      send_byte(8'(8'h40 + i), 4'(4 + i), "sat");
    end
    check_flags("sat_done", 1'b0, 1'b1, 5'd16);
    tick();
    drain("sat");
  endtask

  task automatic test_reset_mid_burst();
    start_burst(4'd3, 5'd8);
    send_byte(8'hE3, 4'd3, "rmid");
    send_byte(8'hE4, 4'd4, "rmid");
    send_byte(8'hE5, 4'd5, "rmid");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    check_flags("rmid_idle", 1'b0, 1'b0, 5'd0);
    tick();
    check_flags("rmid_nodone", 1'b0, 1'b0, 5'd0);
    sweep("rmid");
  endtask

  task automatic test_read_during_write();
    logic [7:0] old;
    model[7] = 8'h3C;
    start_burst(4'd7, 5'd1);
    in_valid = 1'b1; in_data = 8'h3C; tick(); in_valid = 1'b0;
    tick();
    old = model[7];
    start_burst(4'd7, 5'd1);
    addr_a = 4'd7; addr_b = 4'd7;
    in_valid = 1'b1; in_data = 8'h5A; #1;
    total++;
    if (data_a !== old || data_b !== old) begin
      bad++; $display("FAIL rdw_old: a=%h b=%h want %h", data_a, data_b, old);
    end
    model[7] = 8'h5A;
    tick();
    in_valid = 1'b0;
    total++;
    if (data_a !== 8'h5A || data_b !== 8'h5A || done !== 1'b1) begin
      bad++; $display("FAIL rdw_new: a=%h b=%h done=%b want 5a 5a 1", data_a, data_b, done);
    end
    tick();
    sweep("rdw");
  endtask

  initial begin
    test_reset();
    test_full_burst();
    test_wrap_stall();
    test_zero_len();
    test_ignored_start();
    test_saturate();
    test_reset_mid_burst();
    test_read_during_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dp_ram_loader.md
# dp_ram_loader

Writable counterpart to the lab's preloaded dual-port ROM: a 16x8 dual-port RAM plus a burst loader that fills consecutive addresses from a valid/ready byte stream.
- Upstream byte sources (UART RX, switch entry) write lookup tables at run time.
- Two independent combinational read ports (A, B) serve consumers exactly as the ROM did.
- Sits between the byte source and any table-driven datapath in the experiment top.

## Interface
Parameters:
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W = 16
- DATA_W, 8, byte width

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a burst load; sampled only in IDLE
- base_addr  in  ADDR_W  first address written by the burst; latched on accepted start
- len  in  ADDR_W+1  byte count, 0..16; latched on accepted start; values >16 saturate to 16
- in_valid  in  1  upstream byte valid
- in_data  in  DATA_W  upstream byte
- in_ready  out  1  loader accepts a byte this cycle
- busy  out  1  high while in LOAD
- done  out  1  one-cycle pulse on burst completion
- wr_count  out  ADDR_W+1  bytes written in the current or most recent burst
- addr_a, addr_b  in  ADDR_W  read addresses
- data_a, data_b  out  DATA_W  combinational read data, mem[addr_a] / mem[addr_b]

## Operation
- FSM states: IDLE, LOAD, DONE.
- IDLE
  - in_ready=0, busy=0.
  - On start: latch ptr=base_addr, remaining=len (saturated), wr_count=0.
  - If len==0, go to DONE; otherwise go to LOAD.
- LOAD
  - in_ready=1, busy=1.
  - A handshake is in_valid&&in_ready. On a handshake: mem[ptr]<=in_data, ptr<=ptr+1 mod 16, remaining--, wr_count++.
  - The handshake with remaining==1 goes to DONE.
  - in_valid low: stall, no state change.
- DONE: done=1 for exactly one cycle, then IDLE.
- start while not in IDLE is ignored; there is no queueing.
- Address wrap: the pointer wraps 15 -> 0. A burst with base 14 and len 4 writes addresses 14, 15, 0, 1.
- Read ports are always live, independent of the FSM.
  - Same-address reads on A and B are legal.
  - Read-during-write to the same address returns the old value until the write edge and the new value after it.
- Reset, including mid-burst:
  - State goes to IDLE; in_ready, busy, done are 0; wr_count=0.
  - All 16 memory words are cleared to 8'h00.
  - No done pulse is issued for an aborted burst.

## Timing
- start sampled high in IDLE at edge N:
  - LOAD is entered and in_ready=1 from cycle N+1.
  - If len==0, done=1 in cycle N+1 and IDLE from N+2.
- Throughput: one byte per cycle maximum. A len=L burst with in_valid held high completes its last write at edge N+L.
- done=1 in the cycle after the last handshake. busy and in_ready fall in that same cycle.
- Written data appears on data_a/data_b combinationally in the cycle after the write edge.
- wr_count holds its final value after done until the next accepted start.

## Structure
- Package dp_ram_loader_pkg:
  - ADDR_W and DATA_W constants.
  - The state encoding (IDLE=2'd0, LOAD=2'd1, DONE=2'd2).
- Sub-module dp_ram_16x8 holds the storage:
  - one synchronous write port (we, waddr, wdata);
  - synchronous clear on rst;
  - two combinational read ports.
- The loader FSM and counters live in dp_ram_loader, which instantiates dp_ram_16x8.

## Test plan
- Reset then read: assert rst 2 cycles, sweep addr_a/addr_b over 0..15 -> all data 8'h00; in_ready=0, done=0, wr_count=0.
- Full burst: base=0, len=16, stream 8'h12,8'h34,...,8'h88 with in_valid held high -> 16 writes on consecutive edges, done pulse exactly one cycle after the last byte, wr_count=16. Afterwards addr_a=5 gives 8'hBC and addr_b=15 gives 8'h88.
- Wrap and stall: base=14, len=4, bytes A1,A2,A3,A4 with in_valid low for 3 cycles between A2 and A3 -> mem[14]=A1, mem[15]=A2, mem[0]=A3, mem[1]=A4; busy stays high through the stall; other addresses unchanged.
- Zero length and ignored start:
  - len=0 -> done one cycle after start, no writes, wr_count=0.
  - A start pulsed during LOAD -> no effect on ptr or len.
- Reset mid-burst: base=3, len=8, assert rst after 3 bytes -> IDLE next cycle, no done pulse, mem[3..5] read 8'h00.
- Read-during-write: addr_a=addr_b=7, write 8'h5A to addr 7 -> data_a/data_b show the old value in the write cycle and 8'h5A from the next cycle.
